// File: rtl/vp_key_event_tx.sv
// vp_key_event_tx
//   Producer end of the keyboard-event handshake read by vp_keymap. PS/2 key
//   toggles and joystick numpad edges become a queued stream of
//   {released, ascii} events, so events that arrive together or in quick
//   succession are neither merged nor lost.
//
// Ports
//   clk_i            system clock (clk_sys)
//   res_i            asynchronous, active-high reset
//   ps2_key_i[10:0]  [10] event toggle, [9] pressed, [8] extended (unused), [7:0] set-2 scan code
//   joy_numpad_i     numpad buttons of both pads ORed, 1 = pressed; bit0..8 = "1".."9", bit9 = "0"
//   rx_data_ready_o  queue head valid
//   rx_ascii_o       head ASCII code (last head value while the queue is empty)
//   rx_released_o    head is a release event (last head value while empty)
//   rx_read_i        consumer ack, one-cycle pulse, pops the head
//   overflow_o       sticky: a PS/2 event was dropped because the queue was full
//   dbg_state_o      current FSM state (0 = ARM, 1 = RUN)
//
// Handshake: rx_data_ready_o is the valid, rx_read_i is the ack. The head is
//   removed at a rising edge where both are 1, and the head outputs do not
//   change while rx_data_ready_o=1 and no ack is given. An ack while empty is
//   ignored.
module vp_key_event_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int JOY_BITS   = 10
) (
  input  logic                clk_i,
  input  logic                res_i,
  input  logic [10:0]         ps2_key_i,
  input  logic [JOY_BITS-1:0] joy_numpad_i,
  output logic                rx_data_ready_o,
  output logic [7:0]          rx_ascii_o,
  output logic                rx_released_o,
  input  logic                rx_read_i,
  output logic                overflow_o,
  output logic                dbg_state_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int JW = $clog2(JOY_BITS);

  typedef enum logic {ARM = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                prev_tgl_q;
  logic [JOY_BITS-1:0] prev_joy_q;
  logic [JOY_BITS-1:0] pend_press_q, pend_press_d;
  logic [JOY_BITS-1:0] pend_rel_q, pend_rel_d;
  logic [8:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       count_q;
  logic [8:0]          last_q;
  logic                ovf_q;

  logic                running, pop, room, ps2_ev, ovf_set, push;
  logic [8:0]          ps2_map, push_data;
  logic [JOY_BITS-1:0] eff_press, eff_rel, sel_onehot;
  logic                joy_found, joy_is_press;
  logic [JW-1:0]       joy_idx;
  logic [7:0]          joy_ascii;

  // {valid, ascii} for a set-2 scan code; valid=0 means no event.
  function automatic logic [8:0] map_code(input logic [7:0] c);
    logic [8:0] m;
    case (c)
      8'h16: m = 9'h131;  8'h1E: m = 9'h132;  8'h26: m = 9'h133;  8'h25: m = 9'h134;
      8'h2E: m = 9'h135;  8'h36: m = 9'h136;  8'h3D: m = 9'h137;  8'h3E: m = 9'h138;
      8'h46: m = 9'h139;  8'h45: m = 9'h130;
      8'h1C: m = 9'h161;  8'h32: m = 9'h162;  8'h21: m = 9'h163;  8'h23: m = 9'h164;
      8'h24: m = 9'h165;  8'h2B: m = 9'h166;  8'h34: m = 9'h167;  8'h33: m = 9'h168;
      8'h43: m = 9'h169;  8'h3B: m = 9'h16A;  8'h42: m = 9'h16B;  8'h4B: m = 9'h16C;
      8'h3A: m = 9'h16D;  8'h31: m = 9'h16E;  8'h44: m = 9'h16F;  8'h4D: m = 9'h170;
      8'h15: m = 9'h171;  8'h2D: m = 9'h172;  8'h1B: m = 9'h173;  8'h2C: m = 9'h174;
      8'h3C: m = 9'h175;  8'h2A: m = 9'h176;  8'h1D: m = 9'h177;  8'h22: m = 9'h178;
      8'h35: m = 9'h179;  8'h1A: m = 9'h17A;
      8'h29: m = 9'h120;  8'h79: m = 9'h12B;  8'h7B: m = 9'h12D;  8'h7C: m = 9'h12A;
      8'h4A: m = 9'h12F;  8'h55: m = 9'h13D;  8'h1F: m = 9'h111;  8'h27: m = 9'h112;
      8'h5A: m = 9'h10A;  8'h66: m = 9'h108;
      default: m = 9'h000;
    endcase
    return m;
  endfunction

  always_comb begin
    state_d      = state_q;
    running      = (state_q == RUN);
    pop          = rx_read_i && (count_q != '0);
    // A full queue still accepts a push when the head leaves on the same edge.
    room         = (count_q != CW'(FIFO_DEPTH)) || pop;
    ps2_map      = map_code(ps2_key_i[7:0]);
    ps2_ev       = running && (ps2_key_i[10] != prev_tgl_q) && ps2_map[8];
    ovf_set      = 1'b0;
    push         = 1'b0;
    push_data    = '0;
    eff_press    = pend_press_q;
    eff_rel      = pend_rel_q;
    sel_onehot   = '0;
    joy_found    = 1'b0;
    joy_is_press = 1'b0;
    joy_idx      = '0;

    case (state_q)
      ARM:     state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = ARM;
    endcase

    // Edges seen this cycle join the pending masks immediately so they can be
    // pushed on the edge that samples them. A release never cancels a
    // still-pending press: presses are offered first, so the press of a bit
    // always leaves before its release.
    if (running) begin
      eff_press = pend_press_q | (joy_numpad_i & ~prev_joy_q);
      eff_rel   = pend_rel_q   | (~joy_numpad_i & prev_joy_q);
    end

    // Descending scan so the lowest set index is the one left selected.
    for (int i = JOY_BITS - 1; i >= 0; i--) begin
      if (eff_press[i]) begin
        joy_found    = 1'b1;
        joy_is_press = 1'b1;
        joy_idx      = JW'(i);
        sel_onehot   = '0;
        sel_onehot[i] = 1'b1;
      end
    end
    if (!joy_found) begin
      for (int i = JOY_BITS - 1; i >= 0; i--) begin
        if (eff_rel[i]) begin
          joy_found     = 1'b1;
          joy_idx       = JW'(i);
          sel_onehot    = '0;
          sel_onehot[i] = 1'b1;
        end
      end
    end
    joy_ascii = (joy_idx == JW'(9)) ? 8'h30 : 8'h31 + 8'(joy_idx);

    pend_press_d = eff_press;
    pend_rel_d   = eff_rel;

    if (ps2_ev) begin
      if (room) begin
        push      = 1'b1;
        push_data = {~ps2_key_i[9], ps2_map[7:0]};
      end else begin
        ovf_set   = 1'b1;
      end
    end else if (joy_found && room) begin
      push      = 1'b1;
      push_data = {~joy_is_press, joy_ascii};
      if (joy_is_press) pend_press_d = eff_press & ~sel_onehot;
      else              pend_rel_d   = eff_rel   & ~sel_onehot;
    end
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q      <= ARM;
      prev_tgl_q   <= 1'b0;
      prev_joy_q   <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      last_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      // In ARM this captures the baseline; in RUN it tracks every cycle.
      prev_tgl_q   <= ps2_key_i[10];
      prev_joy_q   <= joy_numpad_i;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // Remember the current head so it stays visible once the queue drains.
      if (count_q != '0) last_q <= mem[rd_q];
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_q] <= push_data;
  end

  assign rx_data_ready_o = (count_q != '0);
  assign {rx_released_o, rx_ascii_o} = rx_data_ready_o ? mem[rd_q] : last_q;
  assign overflow_o      = ovf_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_vp_key_event_tx.sv
module tb_vp_key_event_tx;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        res;
  logic [10:0] ps2_key;
  logic [9:0]  joy;
  logic        rd;
  logic        ready, released, overflow, dbg_state;
  logic [7:0]  ascii;

  always #5 clk = ~clk;

  vp_key_event_tx #(.FIFO_DEPTH(4), .JOY_BITS(10)) dut (
    .clk_i           (clk),
    .res_i           (res),
    .ps2_key_i       (ps2_key),
    .joy_numpad_i    (joy),
    .rx_data_ready_o (ready),
    .rx_ascii_o      (ascii),
    .rx_released_o   (released),
    .rx_read_i       (rd),
    .overflow_o      (overflow),
    .dbg_state_o     (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scan-code table ----------------
  logic [7:0] dig_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] oth_codes [10] = '{8'h29, 8'h79, 8'h7B, 8'h7C, 8'h4A, 8'h55, 8'h1F, 8'h27, 8'h5A, 8'h66};
  logic [7:0] oth_ascii [10] = '{8'h20, 8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h3D, 8'h11, 8'h12, 8'h0A, 8'h08};
  logic [8:0] lut [256];

  // ---------------- behavioural model ----------------
  logic [8:0] exp_q[$];
  logic [8:0] m_last;
  logic       m_ovf;
  logic       m_run;
  logic       m_tgl;
  logic [9:0] m_joy;
  logic [9:0] m_press, m_rel;

  initial begin
    forever begin
      @(posedge clk or posedge res);
      if (res) begin
        exp_q.delete();
        m_last = '0; m_ovf = 1'b0; m_run = 1'b0; m_press = '0; m_rel = '0;
      end else if (!m_run) begin
        m_tgl = ps2_key[10];
        m_joy = joy;
        m_run = 1'b1;
      end else begin : run_step
        bit do_pop, has_room, found;
        do_pop   = rd && (exp_q.size() > 0);
        has_room = (exp_q.size() < 4) || do_pop;
        found    = 1'b0;
        if (exp_q.size() > 0) m_last = exp_q[0];
        for (int i = 0; i < 10; i++) begin
          if (joy[i] && !m_joy[i]) m_press[i] = 1'b1;
          if (!joy[i] && m_joy[i]) m_rel[i]   = 1'b1;
        end
        if (do_pop) void'(exp_q.pop_front());
        if (ps2_key[10] != m_tgl && lut[ps2_key[7:0]][8]) begin
          if (has_room) exp_q.push_back({~ps2_key[9], lut[ps2_key[7:0]][7:0]});
          else          m_ovf = 1'b1;
        end else if (has_room) begin
          for (int i = 0; i < 10 && !found; i++)
            if (m_press[i]) begin
              found = 1'b1; m_press[i] = 1'b0;
              exp_q.push_back({1'b0, (i == 9) ? 8'h30 : 8'h31 + 8'(i)});
            end
          for (int i = 0; i < 10 && !found; i++)
            if (m_rel[i]) begin
              found = 1'b1; m_rel[i] = 1'b0;
              exp_q.push_back({1'b1, (i == 9) ? 8'h30 : 8'h31 + 8'(i)});
            end
        end
        m_tgl = ps2_key[10];
        m_joy = joy;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [8:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : m_last;
    check("cyc_ready",    32'(ready),    32'(exp_q.size() > 0));
    check("cyc_ascii",    32'(ascii),    32'(head[7:0]));
    check("cyc_released", 32'(released), 32'(head[8]));
    check("cyc_overflow", 32'(overflow), 32'(m_ovf));
  end

  // ---------------- driver tasks ----------------
  logic tgl = 1'b0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_ps2(input logic [7:0] code, input logic pressed, input logic ext);
    tgl     = ~tgl;
    ps2_key = {tgl, pressed, ext, code};
  endtask

  task automatic pop_expect(input string name, input logic [7:0] a, input logic r);
    check({name, "_ready"}, 32'(ready), 32'd1);
    check({name, "_ascii"}, 32'(ascii), 32'(a));
    check({name, "_rel"},   32'(released), 32'(r));
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) lut[i] = '0;
    for (int i = 0; i < 10; i++) lut[dig_codes[i]] = {1'b1, (i == 9) ? 8'h30 : 8'h31 + 8'(i)};
    for (int i = 0; i < 26; i++) lut[let_codes[i]] = {1'b1, 8'h61 + 8'(i)};
    for (int i = 0; i < 10; i++) lut[oth_codes[i]] = {1'b1, oth_ascii[i]};

    res = 1'b1; ps2_key = '0; joy = 10'h001; rd = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ascii", 32'(ascii), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    res = 1'b0;

    // 1: key held through reset gives no press, its release gives one event
    repeat (3) step();
    check("t1_no_press", 32'(ready), 32'd0);
    check("t1_running",  32'(dbg_state), 32'd1);
    joy = 10'h000;
    step();
    pop_expect("t1_rel1", 8'h31, 1'b1);
    check("t1_empty", 32'(ready), 32'd0);

    // 2: PS/2 'a' press, one-cycle latency, pop, head value held while empty
    send_ps2(8'h1C, 1'b1, 1'b0);
    step();
    pop_expect("t2_a", 8'h61, 1'b0);
    check("t2_empty", 32'(ready), 32'd0);
    check("t2_hold",  32'(ascii), 32'h61);
    send_ps2(8'h00, 1'b1, 1'b0);      // unmapped code
    step(); step();
    check("t2_unmapped", 32'(ready), 32'd0);
    rd = 1'b1; step(); rd = 1'b0;     // ack while empty
    check("t2_empty_read", 32'(ready), 32'd0);
    send_ps2(8'h1C, 1'b0, 1'b1);      // release, extended bit set
    step();
    pop_expect("t2_a_rel", 8'h61, 1'b1);

    // 3: three joystick presses in one cycle, then their releases
    joy = 10'h205;
    step();
    pop_expect("t3_p1", 8'h31, 1'b0);
    pop_expect("t3_p3", 8'h33, 1'b0);
    pop_expect("t3_p0", 8'h30, 1'b0);
    joy = 10'h000;
    step();
    pop_expect("t3_r1", 8'h31, 1'b1);
    pop_expect("t3_r3", 8'h33, 1'b1);
    pop_expect("t3_r0", 8'h30, 1'b1);

    // 4: simultaneous PS/2 and joystick events, PS/2 first
    send_ps2(8'h32, 1'b1, 1'b0);
    joy = 10'h008;
    step();
    pop_expect("t4_b", 8'h62, 1'b0);
    pop_expect("t4_4", 8'h34, 1'b0);
    joy = 10'h000;
    step();
    pop_expect("t4_4rel", 8'h34, 1'b1);

    // 5: fill, overflow on a fifth PS/2 event, joystick event held until a pop
    send_ps2(8'h29, 1'b1, 1'b0); step();
    send_ps2(8'h79, 1'b1, 1'b0); step();
    send_ps2(8'h5A, 1'b1, 1'b0); step();
    send_ps2(8'h66, 1'b1, 1'b0); step();
    check("t5_no_ovf", 32'(overflow), 32'd0);
    send_ps2(8'h1C, 1'b1, 1'b0); step();
    check("t5_ovf", 32'(overflow), 32'd1);
    joy = 10'h002;
    step(); step();
    check("t5_head_held", 32'(ascii), 32'h20);
    pop_expect("t5_sp",   8'h20, 1'b0);
    pop_expect("t5_plus", 8'h2B, 1'b0);
    pop_expect("t5_lf",   8'h0A, 1'b0);
    pop_expect("t5_bs",   8'h08, 1'b0);
    pop_expect("t5_2",    8'h32, 1'b0);
    check("t5_empty",      32'(ready), 32'd0);
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // 6: reset with three entries queued
    joy = 10'h000; step();
    send_ps2(8'h45, 1'b1, 1'b0); step();
    send_ps2(8'h4A, 1'b1, 1'b0); step();
    check("t6_ready_before", 32'(ready), 32'd1);
    res = 1'b1;
    #1;
    check("t6_ready", 32'(ready), 32'd0);
    check("t6_ascii", 32'(ascii), 32'd0);
    check("t6_rel",   32'(released), 32'd0);
    check("t6_ovf",   32'(overflow), 32'd0);
    step(); step();
    res = 1'b0;
    repeat (3) step();
    check("t6_after", 32'(ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
